// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control unit (main FSM + ALU decode) for the
// existing multicycle datapath. Adds a memready handshake with a bounded wait,
// BNE/ANDI/ORI (zero-extend select) and a sticky TRAP for illegal opcodes,
// illegal R-type functs and memory timeouts.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset -> FETCH
//   op, funct         instruction register fields instr[31:26], instr[5:0]
//   zero              ALU zero flag (branch resolution)
//   memready          memory completes the current request this cycle
//   memreq, memwrite  memory request / write qualifier
//   pcen, irwrite, regwrite           datapath register enables
//   alusrca, iord, memtoreg, regdst, immzx, alusrcb, pcsrc, alucontrol
//                                     datapath mux selects and ALU operation
//   trap              sticky fault indicator, cleared only by reset
//   instret           retired-instruction count (MC_PERF_CNT_EN builds only)
//
// Build option: define MC_PERF_CNT_EN to add the instret port and counter.
// Latency: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3 cycles, each
// memory state stretched by one cycle per memready=0 cycle (bounded by MAX_WAIT).

module mc_ctrl_fsm #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       immzx,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       trap
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  // ---------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_BNEEX   = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ANDIEX  = 4'd11;
  localparam logic [3:0] S_ORIEX   = 4'd12;
  localparam logic [3:0] S_IMMWB   = 4'd13;
  localparam logic [3:0] S_JEX     = 4'd14;
  localparam logic [3:0] S_TRAP    = 4'd15;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Last tolerated wait-counter value before a stalled memory state traps.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [3:0]        state;
  logic [3:0]        next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_state;
  logic              timeout;
  logic              funct_ok;
  logic [2:0]        rtype_alu;

  // ---------------------------------------------------------------------
  // R-type ALU decode. Unknown functs leave rtype_alu at 0 and route the
  // FSM to TRAP instead of writeback.
  // ---------------------------------------------------------------------
  always_comb begin
    funct_ok  = 1'b1;
    rtype_alu = 3'b000;
    case (funct)
      FN_ADD:  rtype_alu = ALU_ADD;
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // States that wait on memready; memready is ignored everywhere else.
  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  // A stall reaching MAX_WAIT consecutive cycles traps on the next edge.
  assign timeout = mem_state && !memready && (wait_cnt == WAIT_LAST);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (timeout)       next_state = S_TRAP;
        else if (memready) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_BNE:       next_state = S_BNEEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_ANDI:      next_state = S_ANDIEX;
          OP_ORI:       next_state = S_ORIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = S_TRAP;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but lw is a store.
      S_MEMADR:  next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (timeout)       next_state = S_TRAP;
        else if (memready) next_state = S_MEMWB;
      end
      S_MEMWR: begin
        if (timeout)       next_state = S_TRAP;
        else if (memready) next_state = S_FETCH;
      end
      S_RTYPEEX: next_state = funct_ok ? S_RTYPEWB : S_TRAP;
      S_ADDIEX, S_ANDIEX, S_ORIEX: next_state = S_IMMWB;
      S_MEMWB, S_RTYPEWB, S_IMMWB, S_BEQEX, S_BNEEX, S_JEX: next_state = S_FETCH;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // ---------------------------------------------------------------------
  // Wait counter. Clearing on every state change covers entry into
  // FETCH/MEMRD/MEMWR; the count is only consulted in those states.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if (mem_state && !memready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode. Every output defaults to 0 so states only name what
  // they drive.
  // ---------------------------------------------------------------------
  always_comb begin
    memreq     = 1'b0;
    memwrite   = 1'b0;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    immzx      = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 computed every cycle; only committed once memory answers.
        memreq     = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        pcen       = memready;
        irwrite    = memready;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut.
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_ANDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        immzx      = 1'b1;
        alucontrol = ALU_AND;
      end
      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        immzx      = 1'b1;
        alucontrol = ALU_OR;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
      end
      S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = ~zero;
      end
      S_JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b1;
      end
    endcase

    // State is already FETCH during reset; suppress side-effecting strobes
    // until reset is released.
    if (reset) begin
      memreq   = 1'b0;
      memwrite = 1'b0;
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------
`ifdef MC_PERF_CNT_EN
  logic retire;

  // An instruction retires on the edge that returns a terminal state to
  // FETCH. FETCH holding itself and TRAP never count.
  assign retire = (state != S_FETCH) && (state != S_TRAP) && (next_state == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`else
  // CNT_W only sizes the retired-instruction counter, which this build omits.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: an instruction-level reference model
// pushes the expected control word of every cycle; a negedge monitor pops and
// compares against the DUT outputs.
module tb_mc_ctrl_fsm;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 32;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       immzx;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       trap;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op, funct;
  logic zero, memready;
  logic memreq, memwrite, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, immzx;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic trap;
`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instret;
`endif

  mc_ctrl_fsm #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memreq(memreq), .memwrite(memwrite), .pcen(pcen), .irwrite(irwrite),
    .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .immzx(immzx), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .trap(trap)
`ifdef MC_PERF_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  ctl_t act;
  assign act = {memreq, memwrite, pcen, irwrite, regwrite, alusrca, iord, memtoreg,
                regdst, immzx, alusrcb, pcsrc, alucontrol, trap};

  ctl_t        exp_q[$];
  int unsigned ret_q[$];
  string       tag_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc_no  = 0;
  int unsigned retired = 0;
  bit trapped = 0;

  // Monitor: one expected word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    ctl_t        e;
    int unsigned r;
    string       t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = ret_q.pop_front();
      t = tag_q.pop_front();
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL %s (cycle %0d): ctl got %b required %b", t, cyc_no, act, e);
`ifdef MC_PERF_CNT_EN
      n_total++;
      if (instret === CNT_W'(r)) n_pass++;
      else $display("FAIL %s instret (cycle %0d): got %0d required %0d", t, cyc_no, instret, r);
`endif
    end
    cyc_no++;
  end

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic ctl_t w_fetch(input logic done);
    ctl_t c = '0;
    c.memreq = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
    c.pcen = done; c.irwrite = done;
    return c;
  endfunction

  // One clock cycle: apply memready, record what the DUT must show.
  task automatic cyc(input logic mr, input ctl_t c, input string tag);
    memready = mr;
    exp_q.push_back(c);
    ret_q.push_back(retired);
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  // A memory handshake: 'waits' not-ready cycles then the completing cycle,
  // or a trap once MAX_WAIT consecutive stalls have been seen.
  task automatic mem_phase(input int waits, input ctl_t wait_w, input ctl_t done_w,
                           input string tag, output bit ok);
    int n = (waits < MAX_WAIT) ? waits : MAX_WAIT;
    for (int i = 0; i < n; i++) cyc(1'b0, wait_w, tag);
    if (waits >= MAX_WAIT) begin
      trapped = 1'b1;
      ok = 1'b0;
    end else begin
      cyc(1'b1, done_w, tag);
      ok = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw);
    ctl_t c;
    bit ok;
    bit fok;
    logic [2:0] a;
    string t;
    op = o; funct = f; zero = z;
    mem_phase(fw, w_fetch(1'b0), w_fetch(1'b1), "fetch", ok);
    if (!ok) return;
    c = '0; c.alusrcb = 2'b11; c.alucontrol = 3'b010;
    cyc(rnd(), c, "decode");
    case (o)
      OP_LW, OP_SW: begin
        c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
        cyc(rnd(), c, "memadr");
        c = '0; c.memreq = 1'b1; c.iord = 1'b1; c.memwrite = (o == OP_SW);
        t = (o == OP_SW) ? "memwr" : "memrd";
        mem_phase(mw, c, c, t, ok);
        if (!ok) return;
        if (o == OP_LW) begin
          c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1;
          cyc(rnd(), c, "memwb");
        end
      end
      OP_R: begin
        fok = 1'b1; a = 3'b000;
        case (f)
          6'b100000: a = 3'b010;
          6'b100010: a = 3'b110;
          6'b100100: a = 3'b000;
          6'b100101: a = 3'b001;
          6'b101010: a = 3'b111;
          default:   fok = 1'b0;
        endcase
        c = '0; c.alusrca = 1'b1; c.alucontrol = a;
        cyc(rnd(), c, "rtypeex");
        if (!fok) begin trapped = 1'b1; return; end
        c = '0; c.regwrite = 1'b1; c.regdst = 1'b1;
        cyc(rnd(), c, "rtypewb");
      end
      OP_BEQ, OP_BNE: begin
        c = '0; c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
        c.pcen = (o == OP_BEQ) ? z : !z;
        cyc(rnd(), c, "branch");
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
        c.immzx = (o != OP_ADDI);
        c.alucontrol = (o == OP_ADDI) ? 3'b010 : (o == OP_ANDI) ? 3'b000 : 3'b001;
        cyc(rnd(), c, "immex");
        c = '0; c.regwrite = 1'b1;
        cyc(rnd(), c, "immwb");
      end
      OP_J: begin
        c = '0; c.pcsrc = 2'b10; c.pcen = 1'b1;
        cyc(rnd(), c, "jex");
      end
      default: begin
        trapped = 1'b1;
        return;
      end
    endcase
    retired++;
  endtask

  task automatic do_reset();
    ctl_t c = '0;
    c.alusrcb = 2'b01; c.alucontrol = 3'b010;
    reset = 1'b1;
    retired = 0;
    cyc(rnd(), c, "reset");
    cyc(rnd(), c, "reset");
    reset = 1'b0;
    trapped = 1'b0;
  endtask

  // Trapped: every strobe low regardless of inputs, then reset to recover.
  task automatic trap_hold(input int n);
    ctl_t c = '0;
    c.trap = 1'b1;
    for (int i = 0; i < n; i++) begin
      op = 6'($urandom); zero = rnd();
      cyc(rnd(), c, "trap");
    end
    do_reset();
  endtask

  task automatic expect_trap(input int n);
    n_total++;
    if (trapped) n_pass++;
    else $display("FAIL model expected trap path: got no trap required trap");
    trap_hold(n);
  endtask

  logic [5:0] legal_ops[9];
  logic [5:0] legal_fn[5];

  initial begin
    legal_ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
    legal_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; memready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Directed: basic instructions, handshake stretches, branch polarity.
    run_instr(OP_LW, 6'd0, 1'b0, 0, 0);
    run_instr(OP_LW, 6'd0, 1'b0, 3, 2);
    run_instr(OP_SW, 6'd0, 1'b1, 0, 4);
    run_instr(OP_BNE, 6'd0, 1'b0, 0, 0);
    run_instr(OP_BNE, 6'd0, 1'b1, 0, 0);
    run_instr(OP_BEQ, 6'd0, 1'b0, 1, 0);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(OP_ORI, 6'd0, 1'b0, 0, 0);
    run_instr(OP_ANDI, 6'd0, 1'b0, 0, 0);
    run_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) run_instr(OP_R, legal_fn[i], rnd(), 0, 0);
    run_instr(OP_J, 6'd0, 1'b0, 0, 0);
    // Longest tolerated stall completes.
    run_instr(OP_LW, 6'd0, 1'b0, MAX_WAIT - 1, MAX_WAIT - 1);

    // Fault paths.
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    expect_trap(20);
    run_instr(OP_LW, 6'd0, 1'b0, 0, MAX_WAIT);
    expect_trap(4);
    run_instr(OP_SW, 6'd0, 1'b0, 2, MAX_WAIT + 3);
    expect_trap(4);
    run_instr(OP_J, 6'd0, 1'b0, MAX_WAIT, 0);
    expect_trap(4);
    run_instr(OP_R, 6'b111111, 1'b0, 0, 0);
    expect_trap(4);

    // Randomized instruction stream.
    for (int i = 0; i < 120; i++) begin
      logic [5:0] o, f;
      int fw, mw;
      o  = ($urandom_range(0, 19) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
      f  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
      fw = ($urandom_range(0, 29) == 0) ? MAX_WAIT : $urandom_range(0, 3);
      mw = ($urandom_range(0, 19) == 0) ? MAX_WAIT + 1 : $urandom_range(0, 4);
      run_instr(o, f, rnd(), fw, mw);
      if (trapped) trap_hold($urandom_range(1, 5));
    end

    @(negedge clk); #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending words required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle MIPS control unit, successor to the current main/ALU decoder pair: one FSM plus ALU decode driving the existing multicycle datapath. Adds a memory-ready handshake with parametrised wait-timeout, BNE/ANDI/ORI support with zero-extend select, and a sticky trap state for illegal opcodes and memory timeouts. Sits between instruction register (op/funct) and datapath muxes/enables.

## Interface
Parameters:
- MAX_WAIT, 15: max consecutive memready=0 cycles tolerated in a memory state before trap (1..2^WAIT_W-1)
- WAIT_W, 4: wait-counter width
- CNT_W, 32: retired-instruction counter width (used only with MC_PERF_CNT_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; state -> FETCH
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- memready  in  1  memory completes current request this cycle
- memreq  out  1  memory request valid
- memwrite  out  1  write request (valid only with memreq)
- pcen  out  1  PC register enable
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write
- alusrca  out  1  0=PC, 1=A
- iord  out  1  0=PC, 1=ALUOut address
- memtoreg  out  1  0=ALUOut, 1=Data
- regdst  out  1  0=rt, 1=rd
- immzx  out  1  0=sign-extend, 1=zero-extend immediate
- alusrcb  out  2  00=B, 01=4, 10=imm, 11=imm<<2
- pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- trap  out  1  sticky fault indicator
- instret  out  CNT_W  retired count (only with MC_PERF_CNT_EN)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ADDIEX, ANDIEX, ORIEX, IMMWB, JEX, TRAP.
- DECODE dispatch: lw 100011/sw 101011 -> MEMADR; 000000 -> RTYPEEX; beq 000100 -> BEQEX; bne 000101 -> BNEEX; addi 001000 -> ADDIEX; andi 001100 -> ANDIEX; ori 001101 -> ORIEX; j 000010 -> JEX; any other -> TRAP.
- MEMADR -> MEMRD (lw) / MEMWR (sw); MEMRD -> MEMWB; RTYPEEX -> RTYPEWB; ADDIEX/ANDIEX/ORIEX -> IMMWB; MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX -> FETCH.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00; irwrite and pcen only when memready=1; stay while memready=0.
- DECODE: alusrcb=11, add (branch target into ALUOut).
- MEMADR/ADDIEX: alusrca=1, alusrcb=10, add. ANDIEX: same, immzx=1, and. ORIEX: immzx=1, or.
- MEMRD: memreq=1, iord=1; wait on memready. MEMWR: memreq=1, memwrite=1, iord=1; wait on memready.
- MEMWB: regwrite, memtoreg=1, regdst=0. IMMWB: regwrite, regdst=0, memtoreg=0. RTYPEWB: regwrite, regdst=1.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct -> TRAP at RTYPEWB instead of writeback).
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. BNEEX: same, pcen=~zero. JEX: pcsrc=10, pcen=1.
- Timeout: wait counter cleared on entry to FETCH/MEMRD/MEMWR, increments each memready=0 cycle; memready=0 with counter == MAX_WAIT-1 -> TRAP next edge (no strobe that cycle).
- TRAP: all strobes 0, trap=1, held until reset. Unused outputs 0 in every state.

## Timing
- Zero-wait latencies: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3 cycles.
- Each memory state extends by exactly the number of memready=0 cycles.
- memready ignored outside FETCH/MEMRD/MEMWR.
- Reset asserted: state=FETCH, wait counter 0, trap=0, instret=0; memreq, memwrite, pcen, irwrite, regwrite forced 0 combinationally while reset high. Reset mid-instruction abandons it; first FETCH request appears in the cycle reset deasserts.

## Configuration
- MC_PERF_CNT_EN defined: instret port and CNT_W-bit counter present; increments by 1 on each transition into FETCH from a terminal state (not from TRAP), wraps modulo 2^CNT_W.
- Undefined: no instret port, no counter logic; all other behaviour identical.

## Test plan
- lw, memready held 1: FETCH,DECODE,MEMADR,MEMRD,MEMWB visited; regwrite=1 memtoreg=1 only in cycle 5; irwrite=1 only in cycle 1.
- FETCH with memready low 3 cycles then high: memreq=1 for 4 cycles, single pcen/irwrite pulse on 4th; DECODE on cycle 5.
- bne with zero=0 -> pcen=1, pcsrc=01 in BNEEX; zero=1 -> pcen=0; beq inverse.
- ori: ORIEX immzx=1 alucontrol=001, IMMWB regwrite=1 regdst=0.
- op=111111 in DECODE -> TRAP, trap=1, all strobes 0 for 20 cycles; reset -> FETCH, trap=0.
- MAX_WAIT=15, memready stuck 0 in MEMRD -> TRAP after 15 cycles; with MC_PERF_CNT_EN, 3 completed instructions give instret=3.
